// File: rtl/ins_loader.sv
// ---------------------------------------------------------------------------
// ins_loader
//
// Boot-time instruction loader. Assembles a big-endian byte stream into
// 32-bit words and writes them into the CPU instruction memory at ascending
// word addresses 0..NUM_WORDS-1. The CPU is held in reset (nRST=0) for the
// whole load and released only once every address has been written.
//
// If the program ends early (end_prog), any partial word is discarded and
// the remaining addresses are filled with zero words (NOP), one per cycle.
//
// Every output is driven straight from a register, so no input reaches an
// output through combinational logic.
//
// Parameters
//   NUM_WORDS   words written per load, legal range 1..32
//
// Ports
//   clk         sole clock, rising edge
//   clear       synchronous active-high reset, wins over every other input
//   start       begin a load from IDLE, or a reload from RUN
//   byte_valid  byte_data carries a program byte
//   byte_data   program byte, most significant byte of each word first
//   end_prog    end of program, zero-fill the remaining words
//   byte_ready  loader takes a byte this cycle (LOAD only)
//   InsWrEN     instruction-memory write enable
//   InsWrAddr   instruction-memory word address
//   InsDataIn   instruction word to write
//   nRST        active-low CPU reset, high only in RUN
//   busy        load in progress (LOAD, WRITE or FILL)
//   done        image complete and CPU released (RUN)
//   word_count  words taken from the byte stream in the current or last
//               load; fill words are not counted
// ---------------------------------------------------------------------------
module ins_loader #(
    parameter int NUM_WORDS = 32
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        end_prog,
    output logic        byte_ready,
    output logic        InsWrEN,
    output logic [4:0]  InsWrAddr,
    output logic [31:0] InsDataIn,
    output logic        nRST,
    output logic        busy,
    output logic        done,
    output logic [5:0]  word_count
);

    // Address of the final word. NUM_WORDS is at most 32, so this fits in
    // the 5-bit word address.
    localparam logic [4:0] LAST_ADDR = 5'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,   // CPU held in reset, waiting for start
        ST_LOAD,   // collecting bytes of the current word
        ST_WRITE,  // one-cycle write of a completed word
        ST_FILL,   // writing zero words up to the last address
        ST_RUN     // image complete, CPU released
    } state_e;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic [4:0]  addr_q,       addr_d;        // word address being built/written
    logic [1:0]  byte_cnt_q,   byte_cnt_d;    // bytes held in word_q, wraps at 4
    logic [31:0] word_q,       word_d;        // shift register for the word
    logic [5:0]  word_count_q, word_count_d;  // words taken from the stream

    // Registered outputs
    logic        byte_ready_q, byte_ready_d;
    logic        wr_en_q,      wr_en_d;
    logic [31:0] wr_data_q,    wr_data_d;
    logic        nrst_q,       nrst_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;

    // A byte is taken only when it is offered and the loader is listening;
    // byte_ready_q is high exactly while the FSM sits in LOAD.
    logic byte_accept;
    assign byte_accept = byte_valid & byte_ready_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        wr_en_d      = 1'b0;
        wr_data_d    = 32'h0000_0000;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                // A start in RUN is a reload: the CPU goes straight back
                // into reset because the next state is LOAD.
                if (start) begin
                    state_d      = ST_LOAD;
                    addr_d       = '0;
                    byte_cnt_d   = '0;
                    word_count_d = '0;
                end
            end

            ST_LOAD: begin
                if (end_prog) begin
                    // end_prog wins over a byte offered in the same cycle:
                    // that byte and any partial word are dropped, and the
                    // fill starts at the address that was being assembled.
                    state_d    = ST_FILL;
                    byte_cnt_d = '0;
                    wr_en_d    = 1'b1;
                end else if (byte_accept) begin
                    word_d     = {word_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d      = ST_WRITE;
                        word_count_d = word_count_q + 6'd1;
                        wr_en_d      = 1'b1;
                        wr_data_d    = word_d;
                    end
                end
            end

            ST_WRITE: begin
                // Exactly one write cycle per word; end_prog and start have
                // no effect here.
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                    addr_d  = addr_q + 5'd1;
                end
            end

            ST_FILL: begin
                // One zero word per cycle until the last address is written.
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    addr_d  = addr_q + 5'd1;
                    wr_en_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the state being entered, so the
        // registered copies line up with the state they describe.
        byte_ready_d = (state_d == ST_LOAD);
        nrst_d       = (state_d == ST_RUN);
        done_d       = (state_d == ST_RUN);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_WRITE) ||
                       (state_d == ST_FILL);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (clear) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            word_count_q <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            nrst_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            nrst_q       <= nrst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // addr_q holds the address being written in WRITE and FILL.
    assign byte_ready = byte_ready_q;
    assign InsWrEN    = wr_en_q;
    assign InsWrAddr  = addr_q;
    assign InsDataIn  = wr_data_q;
    assign nRST       = nrst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_ins_loader.sv
// ---------------------------------------------------------------------------
// tb_ins_loader
//
// Two loader instances: dut0 with NUM_WORDS=4 and dut1 with NUM_WORDS=32.
// They share clear and the byte-stream inputs but have separate start lines;
// only the instance selected by 'sel' is started, the other sits in IDLE or
// RUN where the stream inputs have no effect. Expected writes {addr, data}
// are queued as stimulus is prepared and popped by a monitor whenever the
// selected instance asserts InsWrEN.
// ---------------------------------------------------------------------------
module tb_ins_loader;

    logic        clk = 1'b0;
    logic        clear;
    logic        start0, start1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        end_prog;

    logic        rdy0, wen0, nrst0, busy0, done0;
    logic [4:0]  addr0;
    logic [31:0] data0;
    logic [5:0]  wc0;
    logic        rdy1, wen1, nrst1, busy1, done1;
    logic [4:0]  addr1;
    logic [31:0] data1;
    logic [5:0]  wc1;

    ins_loader #(.NUM_WORDS(4)) dut0 (
        .clk(clk), .clear(clear), .start(start0), .byte_valid(byte_valid),
        .byte_data(byte_data), .end_prog(end_prog), .byte_ready(rdy0),
        .InsWrEN(wen0), .InsWrAddr(addr0), .InsDataIn(data0), .nRST(nrst0),
        .busy(busy0), .done(done0), .word_count(wc0)
    );

    ins_loader #(.NUM_WORDS(32)) dut1 (
        .clk(clk), .clear(clear), .start(start1), .byte_valid(byte_valid),
        .byte_data(byte_data), .end_prog(end_prog), .byte_ready(rdy1),
        .InsWrEN(wen1), .InsWrAddr(addr1), .InsDataIn(data1), .nRST(nrst1),
        .busy(busy1), .done(done1), .word_count(wc1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Selected-instance views
    bit          sel = 1'b0;
    logic        rdy_s, wen_s, nrst_s, busy_s, done_s, wen_o;
    logic [4:0]  addr_s;
    logic [31:0] data_s;
    logic [5:0]  wc_s;

    always_comb begin
        rdy_s  = sel ? rdy1  : rdy0;
        wen_s  = sel ? wen1  : wen0;
        nrst_s = sel ? nrst1 : nrst0;
        busy_s = sel ? busy1 : busy0;
        done_s = sel ? done1 : done0;
        addr_s = sel ? addr1 : addr0;
        data_s = sel ? data1 : data0;
        wc_s   = sel ? wc1   : wc0;
        wen_o  = sel ? wen0  : wen1;
    end

    int n_checks = 0;
    int n_bad    = 0;

    logic [36:0] exp_q[$];  // {addr, data}
    logic [7:0]  tx_q[$];   // bytes still to send

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic pulse_start();
        set_start(1'b1);
        tick();
        set_start(1'b0);
    endtask

    // Queue a word's bytes (most significant first) and its expected write.
    task automatic add_word(input logic [4:0] addr, input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
        exp_q.push_back({addr, w});
    endtask

    task automatic add_fill(input int first, input int last);
        for (int a = first; a <= last; a++) exp_q.push_back({5'(a), 32'h0});
    endtask

    // Offer bytes from tx_q; a byte is retired when it was offered while
    // byte_ready was high before the edge. 'toggle' gates byte_valid on
    // alternate cycles, 'noise' holds start high throughout.
    task automatic send_stream(input bit toggle, input bit noise);
        int  guard = 0;
        bit  phase = 1'b1;
        bit  acc;
        while (tx_q.size() > 0 && guard < 2000) begin
            byte_data  = tx_q[0];
            byte_valid = toggle ? phase : 1'b1;
            if (noise) set_start(1'b1);
            acc = byte_valid && rdy_s;
            tick();
            if (acc) void'(tx_q.pop_front());
            phase = ~phase;
            guard++;
        end
        byte_valid = 1'b0;
        set_start(1'b0);
        check("stream_drained", 64'(tx_q.size()), 64'd0);
    endtask

    // Hold end_prog (optionally with a byte) until it lands in a LOAD cycle.
    task automatic send_end(input bit with_byte, input logic [7:0] b);
        int guard = 0;
        bit acc   = 1'b0;
        end_prog   = 1'b1;
        byte_valid = with_byte;
        byte_data  = b;
        while (!acc && guard < 50) begin
            acc = rdy_s;
            tick();
            guard++;
        end
        end_prog   = 1'b0;
        byte_valid = 1'b0;
        check("end_prog_taken", 64'(acc), 64'd1);
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (!nrst_s && n < budget) begin
            tick();
            n++;
        end
        check("reach_run", 64'(nrst_s), 64'd1);
    endtask

    // Write monitor, sampling on the falling edge.
    always @(negedge clk) begin
        logic [36:0] e;
        if (wen_s) begin
            check("rdy_low_in_write", 64'(rdy_s), 64'd0);
            check("nrst_low_in_write", 64'(nrst_s), 64'd0);
            if (exp_q.size() == 0) begin
                check("extra_write", 64'(wen_s), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr_data", 64'({addr_s, data_s}), 64'(e));
            end
        end
        if (wen_o) check("other_dut_write", 64'(wen_o), 64'd0);
    end

    int c0;

    initial begin
        clear      = 1'b1;
        start0     = 1'b0;
        start1     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        end_prog   = 1'b0;
        tick();
        tick();
        clear = 1'b0;

        // Reset values of both instances
        check("reset_outs0", 64'({rdy0, wen0, addr0, data0, nrst0, busy0, done0, wc0}), 64'd0);
        check("reset_outs1", 64'({rdy1, wen1, addr1, data1, nrst1, busy1, done1, wc1}), 64'd0);

        // ---- NUM_WORDS=4: bytes 00..0F continuous ----
        sel = 1'b0;
        for (int w = 0; w < 4; w++) begin
            logic [7:0] b;
            b = 8'(4 * w);
            add_word(5'(w), {b, b + 8'd1, b + 8'd2, b + 8'd3});
        end
        pulse_start();
        c0 = cyc;
        check("busy_after_start", 64'(busy_s), 64'd1);
        send_stream(1'b0, 1'b0);
        wait_run(100);
        check("load_to_run_cycles", 64'(cyc - c0), 64'd20);
        check("full_done", 64'(done_s), 64'd1);
        check("full_busy", 64'(busy_s), 64'd0);
        check("full_word_count", 64'(wc_s), 64'd4);
        check("full_all_written", 64'(exp_q.size()), 64'd0);

        // ---- Reload from RUN; 11,22 then end_prog with byte 33 ----
        add_fill(0, 3);
        pulse_start();
        check("reload_nrst_low", 64'(nrst_s), 64'd0);
        check("reload_word_count", 64'(wc_s), 64'd0);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        send_stream(1'b0, 1'b0);
        check("rdy_before_end", 64'(rdy_s), 64'd1);
        send_end(1'b1, 8'h33);
        wait_run(100);
        check("partial_word_count", 64'(wc_s), 64'd0);
        check("partial_all_written", 64'(exp_q.size()), 64'd0);

        // ---- Toggling byte_valid with start held high during the load ----
        for (int w = 0; w < 4; w++) begin
            logic [7:0] b;
            b = 8'(8'hA0 + 4 * w);
            add_word(5'(w), {b, b + 8'd1, b + 8'd2, b + 8'd3});
        end
        pulse_start();
        send_stream(1'b1, 1'b1);
        wait_run(200);
        check("toggle_word_count", 64'(wc_s), 64'd4);
        check("toggle_all_written", 64'(exp_q.size()), 64'd0);

        // ---- NUM_WORDS=32: two words then end_prog, 30-word fill ----
        sel = 1'b1;
        add_word(5'd0, 32'h8C01_0000);
        add_word(5'd1, 32'h0000_0000);
        add_fill(2, 31);
        pulse_start();
        send_stream(1'b0, 1'b0);
        send_end(1'b0, 8'h00);
        c0 = cyc;
        wait_run(100);
        check("fill_cycles", 64'(cyc - c0), 64'd30);
        check("fill_done", 64'(done_s), 64'd1);
        check("fill_word_count", 64'(wc_s), 64'd2);
        check("fill_all_written", 64'(exp_q.size()), 64'd0);

        // ---- clear during FILL at addr 10 ----
        add_fill(0, 10);
        pulse_start();
        send_end(1'b0, 8'h00);
        begin
            int g = 0;
            while (!(wen_s && addr_s == 5'd10) && g < 100) begin
                tick();
                g++;
            end
        end
        check("fill_reached_addr10", 64'(addr_s), 64'd10);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_byte_ready", 64'(rdy1), 64'd0);
        check("clr_wr_en", 64'(wen1), 64'd0);
        check("clr_wr_addr", 64'(addr1), 64'd0);
        check("clr_wr_data", 64'(data1), 64'd0);
        check("clr_nrst", 64'(nrst1), 64'd0);
        check("clr_busy", 64'(busy1), 64'd0);
        check("clr_done", 64'(done1), 64'd0);
        check("clr_word_count", 64'(wc1), 64'd0);
        check("clr_writes_seen", 64'(exp_q.size()), 64'd0);
        repeat (5) tick();
        check("clr_stays_idle", 64'(busy1), 64'd0);

        // ---- Reload after clear starts again at addr 0 ----
        add_word(5'd0, 32'hCAFE_F00D);
        add_fill(1, 31);
        pulse_start();
        send_stream(1'b0, 1'b0);
        send_end(1'b0, 8'h00);
        wait_run(100);
        check("after_clr_word_count", 64'(wc_s), 64'd1);
        check("after_clr_all_written", 64'(exp_q.size()), 64'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 Parameter: NUM_WORDS, default 32, number of instruction-memory words written per load (legal 1..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a load (one-cycle pulse or level).
REQ-005 byte_valid  input  1  program byte present on byte_data.
REQ-006 byte_data  input  8  program byte stream, big-endian within each 32-bit word.
REQ-007 end_prog  input  1  end of program; remaining words zero-filled.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 InsWrEN  output  1  instruction-memory write enable to the CPU.
REQ-010 InsWrAddr  output  5  instruction-memory word address.
REQ-011 InsDataIn  output  32  instruction word to write.
REQ-012 nRST  output  1  active-low CPU reset; CPU runs only when 1.
REQ-013 busy  output  1  load in progress (LOAD, WRITE or FILL).
REQ-014 done  output  1  image complete, CPU released.
REQ-015 word_count  output  6  words taken from the byte stream in the current/last load (fill words excluded).

Function
REQ-016 States SHALL be IDLE, LOAD, WRITE, FILL, RUN, all encoded in registers; every output SHALL be decoded from registered state/datapath only, with no input-to-output combinational path.
REQ-017 IDLE: byte_ready=0, InsWrEN=0, nRST=0, done=0; start=1 -> LOAD with addr=0, byte_cnt=0, word_count=0.
REQ-018 LOAD: byte_ready=1; a byte SHALL be accepted only when byte_valid & byte_ready; accepted byte shifts in as word <= {word[23:0], byte_data}; byte_cnt increments mod 4.
REQ-019 LOAD: acceptance of the 4th byte of a word SHALL move to WRITE next cycle and increment word_count.
REQ-020 WRITE: exactly one cycle, InsWrEN=1, InsWrAddr=addr, InsDataIn=word, byte_ready=0; then addr==NUM_WORDS-1 -> RUN, else addr+1 and -> LOAD.
REQ-021 LOAD with end_prog=1: partial word (byte_cnt!=0) SHALL be discarded, byte_cnt cleared, -> FILL at current addr; end_prog SHALL win over a simultaneous byte_valid (byte not accepted; byte_ready remains 1 in that cycle but the byte is dropped).
REQ-022 FILL: InsWrEN=1 every cycle, InsDataIn=32'h00000000 (NOP), InsWrAddr=addr; addr increments each cycle; write at addr==NUM_WORDS-1 is last, then -> RUN.
REQ-023 end_prog in WRITE SHALL be ignored; end_prog outside LOAD has no effect.
REQ-024 RUN: nRST=1, done=1, busy=0, byte_ready=0, InsWrEN=0; start=1 -> LOAD with nRST=0 the following cycle, addr=0, word_count=0 (reload).
REQ-025 start in LOAD, WRITE or FILL SHALL be ignored.
REQ-026 Addresses SHALL never exceed NUM_WORDS-1; each address 0..NUM_WORDS-1 SHALL be written exactly once per completed load, in ascending order.
REQ-027 Latency: N bytes with byte_valid held high produce the first InsWrEN in the cycle after the 4th accepted byte; a full NUM_WORDS load with continuous valid SHALL take 5*NUM_WORDS cycles from LOAD entry to RUN entry.
REQ-028 nRST SHALL be 0 in every state except RUN; the CPU SHALL never run while InsWrEN can be asserted.

Reset
REQ-029 clear=1 at a clock edge SHALL force IDLE, addr=0, byte_cnt=0, word=0, word_count=0 and outputs byte_ready=0, InsWrEN=0, InsWrAddr=0, InsDataIn=0, nRST=0, busy=0, done=0.
REQ-030 clear SHALL take priority over start, byte_valid and end_prog in the same cycle; clear mid-load SHALL abandon the load with no further writes.

Verification
REQ-031 NUM_WORDS=4, start, 16 bytes 00..0F continuous -> writes addr0=00010203, addr1=04050607, addr2=08090A0B, addr3=0C0D0E0F, one-cycle InsWrEN each; nRST rises 20 cycles after LOAD entry; word_count=4.
REQ-032 NUM_WORDS=32, 2 words (8C010000, 00000000) then end_prog -> addr0..1 written with data, addr2..31 written 0 on 30 consecutive cycles, done=1, word_count=2.
REQ-033 Bytes 11,22 then end_prog together with byte_valid (byte 33) -> partial word discarded, 33 dropped, addr0..NUM_WORDS-1 all written 0, word_count=0.
REQ-034 byte_valid toggling 1/0 every cycle -> same write data/addresses as continuous stream, no duplicate or lost bytes; byte_ready=0 during each WRITE cycle.
REQ-035 clear asserted in FILL at addr=10 -> next cycle IDLE, InsWrEN=0, nRST=0, all outputs at reset values; subsequent start reloads from addr 0.
REQ-036 In RUN, start pulse -> nRST=0 next cycle, reload writes addr 0 first; start pulses during LOAD ignored.
